ula_nbits_seq: RTL and testbench
================================

# ula_nbits_seq

Parametrised, sequential ALU for the FPGA datapath. It registers its operands on a `start`/`done` handshake and computes eight operations over `WIDTH` bits. Multiply is iterative shift-add and divide is iterative restoring division, each taking `WIDTH` cycles. Outputs are registered results and status flags. It replaces the fixed 8-bit combinational ALU wherever a wider word, a result high half, or flags are needed.

## Interface
- `WIDTH`, default 8: operand and result width; legal range is ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `a` in `WIDTH`: operand A; unsigned, or two's complement for the overflow flag.
- `b` in `WIDTH`: operand B.
- `sel_op` in 3: operation code. 0 add, 1 sub, 2 mult, 3 div, 4 and, 5 or, 6 xor, 7 not (uses A only).
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse when the result is valid.
- `resultado_ula` out `WIDTH`: main result (low product, or quotient for div).
- `resultado_alto` out `WIDTH`: high product for mult, remainder for div, 0 otherwise.
- `flag_zero` out 1: `resultado_ula` == 0.
- `flag_negativo` out 1: MSB of `resultado_ula`.
- `flag_carry` out 1: carry or borrow, or a nonzero high product.
- `flag_overflow` out 1: signed overflow for add and sub.
- `flag_div_zero` out 1: a divide was attempted with B == 0.

## Operation
- FSM states: IDLE, EXEC, MULT, DIV.
- **IDLE:**
  - When `start` = 1, latch `a`, `b`, `sel_op`.
  - Go to MULT if op = 2, to DIV if op = 3 and B ≠ 0, otherwise to EXEC.
- **EXEC:**
  - Compute and register the result and flags.
  - Pulse `done`, return to IDLE.
- **MULT:**
  - Run a `WIDTH`-step shift-add over a 2·`WIDTH` accumulator.
  - Step counter width is clog2(`WIDTH`+1).
  - After the last step, register the low half to `resultado_ula` and the high half to `resultado_alto`, pulse `done`, go to IDLE.
- **DIV:**
  - Run `WIDTH` unsigned restoring steps.
  - Quotient goes to `resultado_ula`, remainder to `resultado_alto`.
  - Pulse `done`, go to IDLE.
- **Arithmetic and flag rules:**
  - **Add:** `flag_carry` = carry-out; `flag_overflow` = (A[msb] == B[msb]) && (R[msb] ≠ A[msb]).
  - **Sub:** computes A−B mod 2^`WIDTH`; `flag_carry` = borrow (A < B unsigned); `flag_overflow` = (A[msb] ≠ B[msb]) && (R[msb] ≠ A[msb]).
  - **Mult:** `flag_carry` = (high half ≠ 0); `flag_overflow` = 0.
  - **Logic ops and div:** `flag_carry` = `flag_overflow` = 0.
  - **Div by zero:** takes the EXEC path. Quotient = all ones, remainder = A, `flag_div_zero` = 1.
  - `flag_div_zero` = 0 for every other op.
  - `flag_zero` and `flag_negativo` are derived from `resultado_ula` for all ops.
- **Output hold:** results and flags update only on the `done` edge and hold until the next `done`.
- **Boundary conditions:**
  - `start` while `busy` is ignored; it is neither queued nor an error.
  - `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE.
  - Changes on `a`, `b`, `sel_op` after the latch edge have no effect on the operation in flight.
  - `rst_n` low at any time aborts the operation: FSM to IDLE, no `done` pulse.

## Timing
- Let E be the edge that samples `start` = 1 in IDLE.
- `busy` is 1 from E until the edge that raises `done`. It is 0 in the cycle `done` is high.
- Latencies from E to the edge that raises `done`:
  - Add, sub, logic ops, div-by-zero: edge E+1.
  - Mult and div: edge E+`WIDTH`+1.
- `done` is high for exactly one cycle.
- Back-to-back throughput: one simple op every 2 cycles; mult or div every `WIDTH`+2 cycles.
- Reset values: all outputs 0, internal registers 0, state IDLE.

## Configuration
- **Macro:** `ULA_DIV_EN`.
- **Defined:** the DIV state and restoring divider are compiled in, and behave as specified above.
- **Undefined:**
  - No divider logic is built.
  - Op 3 takes the EXEC path with latency E+1.
  - `resultado_ula` = 0, `resultado_alto` = 0, `flag_div_zero` = 0, `flag_zero` = 1.

## Test plan
All scenarios run with `WIDTH`=8.
- **Add with carry:** add 200+100 → `resultado_ula`=44, carry=1, overflow=0; `done` at edge E+1.
- **Signed overflow:** add 127+1 → 128, overflow=1, negativo=1. Sub 5−10 → 251, carry=1, negativo=1.
- **Multiply:**
  - 200×200 → low 0x40, high 0x9C, carry=1; `done` at E+9, `busy` high for 9 cycles.
  - 0×77 → 0, zero=1.
- **Divide:**
  - 200÷7 → quotient 28, remainder 4; `done` at E+9.
  - 200÷0 → quotient 255, remainder 200, div_zero=1; `done` at E+1.
  - Repeat 200÷7 with `ULA_DIV_EN` undefined → quotient 0, zero=1.
- **Handshake:**
  - Pulse `start` with xor 0xF0^0x3C mid-multiply → ignored; the mult result is unaffected.
  - Assert `start` in the `done` cycle → the new op is accepted.
- **Reset mid-operation:** drop `rst_n` at E+4 of a multiply → all outputs 0 immediately, no `done`. A fresh `start` after release completes normally.

Source files
------------

// File: rtl/ula_if.sv
// Request/response bundle for the sequential ALU: operands and op code in,
// handshake, results and status flags out.
interface ula_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel_op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] resultado_ula;
    logic [WIDTH-1:0] resultado_alto;
    logic             flag_zero;
    logic             flag_negativo;
    logic             flag_carry;
    logic             flag_overflow;
    logic             flag_div_zero;

    modport master (
        output start, a, b, sel_op,
        input  busy, done, resultado_ula, resultado_alto,
        input  flag_zero, flag_negativo, flag_carry, flag_overflow, flag_div_zero
    );

    modport slave (
        input  start, a, b, sel_op,
        output busy, done, resultado_ula, resultado_alto,
        output flag_zero, flag_negativo, flag_carry, flag_overflow, flag_div_zero
    );
endinterface

// File: rtl/ula_nbits_seq.sv
// Sequential WIDTH-bit ALU: shift-add multiply, restoring divide, registered flags.
// Define ULA_DIV_EN to build the divider; without it op 3 returns zero in one step.
module ula_nbits_seq #(
    parameter int WIDTH = 8
) (
    input logic   clk,
    input logic   rst_n,
    ula_if.slave  bus
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, EXEC, MULT, DIV} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2:0]         op_r;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   hi_r;
    logic               zero_r;
    logic               neg_r;
    logic               carry_r;
    logic               ovf_r;
    logic               dz_r;

    // Single-step operations, evaluated from the latched operands.
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH-1:0]   ex_lo;
    logic [WIDTH-1:0]   ex_hi;
    logic               ex_c;
    logic               ex_v;
    logic               ex_dz;

    assign add_w = {1'b0, a_r} + {1'b0, b_r};
    assign sub_w = {1'b0, a_r} - {1'b0, b_r};

    always_comb begin
        ex_lo = '0;
        ex_hi = '0;
        ex_c  = 1'b0;
        ex_v  = 1'b0;
        ex_dz = 1'b0;
        case (op_r)
            3'd0: begin
                ex_lo = add_w[WIDTH-1:0];
                ex_c  = add_w[WIDTH];
                ex_v  = (a_r[MSB] == b_r[MSB]) && (add_w[MSB] != a_r[MSB]);
            end
            3'd1: begin
                ex_lo = sub_w[WIDTH-1:0];
                ex_c  = sub_w[WIDTH];
                ex_v  = (a_r[MSB] != b_r[MSB]) && (sub_w[MSB] != a_r[MSB]);
            end
            3'd3: begin
`ifdef ULA_DIV_EN
                // Only divide-by-zero reaches the single-step path.
                if (b_r == '0) begin
                    ex_lo = '1;
                    ex_hi = a_r;
                    ex_dz = 1'b1;
                end
`endif
            end
            3'd4: ex_lo = a_r & b_r;
            3'd5: ex_lo = a_r | b_r;
            3'd6: ex_lo = a_r ^ b_r;
            3'd7: ex_lo = ~a_r;
            default: ;
        endcase
    end

    // Shift-add: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                      (acc[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef ULA_DIV_EN
    // Restoring divide: acc = {remainder, dividend shifting into quotient}.
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_tr;
    logic [2*WIDTH-1:0] div_next;

    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_tr   = div_sh - {1'b0, b_r};
    assign div_next = div_tr[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_tr[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`endif

    logic               fin;
    logic [WIDTH-1:0]   fin_lo;
    logic [WIDTH-1:0]   fin_hi;
    logic               fin_c;
    logic               fin_v;
    logic               fin_dz;

    always_comb begin
        fin    = 1'b0;
        fin_lo = ex_lo;
        fin_hi = ex_hi;
        fin_c  = ex_c;
        fin_v  = ex_v;
        fin_dz = ex_dz;
        case (state)
            EXEC: fin = 1'b1;
            MULT: begin
                fin    = (cnt == CW'(WIDTH));
                fin_lo = acc[WIDTH-1:0];
                fin_hi = acc[2*WIDTH-1:WIDTH];
                fin_c  = |acc[2*WIDTH-1:WIDTH];
                fin_v  = 1'b0;
                fin_dz = 1'b0;
            end
            DIV: begin
                fin    = (cnt == CW'(WIDTH));
                fin_lo = acc[WIDTH-1:0];
                fin_hi = acc[2*WIDTH-1:WIDTH];
                fin_c  = 1'b0;
                fin_v  = 1'b0;
                fin_dz = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= '0;
            acc     <= '0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            lo_r    <= '0;
            hi_r    <= '0;
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        op_r   <= bus.sel_op;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        if (bus.sel_op == 3'd2) begin
                            acc   <= {{WIDTH{1'b0}}, bus.b};
                            state <= MULT;
`ifdef ULA_DIV_EN
                        end else if (bus.sel_op == 3'd3 && bus.b != '0) begin
                            acc   <= {{WIDTH{1'b0}}, bus.a};
                            state <= DIV;
`endif
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                MULT: begin
                    if (!fin) begin
                        acc <= mul_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
`ifdef ULA_DIV_EN
                    if (!fin) begin
                        acc <= div_next;
                        cnt <= cnt + 1'b1;
                    end
`else
                    state  <= IDLE;
                    busy_r <= 1'b0;
`endif
                end
                default: ;
            endcase

            // Results and flags move only on the done edge.
            if (fin) begin
                state   <= IDLE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                lo_r    <= fin_lo;
                hi_r    <= fin_hi;
                zero_r  <= (fin_lo == '0);
                neg_r   <= fin_lo[MSB];
                carry_r <= fin_c;
                ovf_r   <= fin_v;
                dz_r    <= fin_dz;
            end
        end
    end

    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.resultado_ula  = lo_r;
    assign bus.resultado_alto = hi_r;
    assign bus.flag_zero      = zero_r;
    assign bus.flag_negativo  = neg_r;
    assign bus.flag_carry     = carry_r;
    assign bus.flag_overflow  = ovf_r;
    assign bus.flag_div_zero  = dz_r;
endmodule

// File: tb/tb_ula_nbits_seq.sv
// Randomised and directed bench for ula_nbits_seq at WIDTH=8, checked against
// an arithmetic reference model (handles both ULA_DIV_EN builds).
module tb_ula_nbits_seq;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ula_if #(.WIDTH(W)) bus ();

    ula_nbits_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int lo; int hi; int z; int n; int c; int v; int dz; int lat;
    } exp_t;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int sa, sb, s;
        e = '{default: 0};
        e.lat = 1;
        sa = (a > MASK / 2) ? a - (MASK + 1) : a;
        sb = (b > MASK / 2) ? b - (MASK + 1) : b;
        case (op)
            0: begin
                s = a + b;
                e.lo = s & MASK;
                e.c = (s > MASK);
                e.v = (sa + sb > MASK / 2) || (sa + sb < -(MASK / 2) - 1);
            end
            1: begin
                e.lo = (a - b) & MASK;
                e.c = (a < b);
                e.v = (sa - sb > MASK / 2) || (sa - sb < -(MASK / 2) - 1);
            end
            2: begin
                s = a * b;
                e.lo = s & MASK;
                e.hi = s >> W;
                e.c = (e.hi != 0);
                e.lat = W + 1;
            end
            3: begin
`ifdef ULA_DIV_EN
                if (b == 0) begin
                    e.lo = MASK; e.hi = a; e.dz = 1;
                end else begin
                    e.lo = a / b; e.hi = a % b; e.lat = W + 1;
                end
`endif
            end
            4: e.lo = a & b;
            5: e.lo = a | b;
            6: e.lo = a ^ b;
            default: e.lo = (~a) & MASK;
        endcase
        e.z = (e.lo == 0);
        e.n = (e.lo >> (W - 1)) & 1;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int a, input int b, input int op);
        bus.start  = 1'b1;
        bus.a      = W'(a);
        bus.b      = W'(b);
        bus.sel_op = 3'(op);
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.a      = W'($urandom);
        bus.b      = W'($urandom);
        bus.sel_op = 3'($urandom);
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, "_lo"},   bus.resultado_ula,  e.lo);
        chk({tag, "_hi"},   bus.resultado_alto, e.hi);
        chk({tag, "_zero"}, bus.flag_zero,      e.z);
        chk({tag, "_neg"},  bus.flag_negativo,  e.n);
        chk({tag, "_cy"},   bus.flag_carry,     e.c);
        chk({tag, "_ov"},   bus.flag_overflow,  e.v);
        chk({tag, "_dz"},   bus.flag_div_zero,  e.dz);
    endtask

    // Counts edges from the accepting edge to done; optionally pulses a
    // stray xor request at edge count 'poke' while the op is running.
    task automatic wait_check(input string tag, input exp_t e, input int poke);
        int n = 0;
        int busy_bad = 0;
        while (!bus.done && n < 40) begin
            if (!bus.busy) busy_bad++;
            if (n == poke) begin
                bus.start = 1'b1; bus.a = 8'hF0; bus.b = 8'h3C; bus.sel_op = 3'd6;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk({tag, "_lat"}, n, e.lat);
        chk({tag, "_busy_run"}, busy_bad, 0);
        chk({tag, "_busy_done"}, bus.busy, 0);
        chk_out(tag, e);
    endtask

    task automatic hold_check(input string tag, input exp_t e);
        @(negedge clk);
        chk({tag, "_done_pulse"}, bus.done, 0);
        chk({tag, "_hold_lo"}, bus.resultado_ula, e.lo);
        chk({tag, "_hold_hi"}, bus.resultado_alto, e.hi);
    endtask

    task automatic run(input string tag, input int a, input int b, input int op);
        exp_t e;
        e = model(a, b, op);
        issue(a, b, op);
        wait_check(tag, e, -1);
        hold_check(tag, e);
    endtask

    int da [11] = '{200, 127,  5, 200,  0, 200, 200, 8'hF0, 8'h55, 8'hA5, 8'hA0};
    int db [11] = '{100,   1, 10, 200, 77,   7,   0, 8'h3C,     0, 8'h0F, 8'h05};
    int dop[11] = '{  0,   0,  1,   2,  2,   3,   3,     6,     7,     4,     5};

    initial begin
        exp_t e, e2, z;
        int ra, rb, rop;
        z = '{default: 0};
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sel_op = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk_out("rst", z);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++)
            run($sformatf("dir%0d", i), da[i], db[i], dop[i]);

        // Stray start mid-multiply must be ignored.
        e = model(200, 200, 2);
        issue(200, 200, 2);
        wait_check("poke", e, 3);
        hold_check("poke", e);

        // Start in the done cycle is accepted.
        e  = model(13, 11, 2);
        e2 = model(50, 60, 0);
        issue(13, 11, 2);
        wait_check("chain_a", e, -1);
        issue(50, 60, 0);
        wait_check("chain_b", e2, -1);
        hold_check("chain_b", e2);

        // Reset mid-multiply clears everything and suppresses done.
        issue(200, 200, 2);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_done", bus.done, 0);
        chk_out("mrst", z);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_nodone", bus.done, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_nodone", bus.done, 0);
        end
        run("fresh", 9, 9, 2);

        for (int i = 0; i < 80; i++) begin
            ra  = int'($urandom_range(0, MASK));
            rb  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MASK));
            rop = int'($urandom_range(0, 7));
            run($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
